// File: rtl/etapa_mem_wb.sv
// MEM stage: word-addressed data memory, branch resolution and MEM/WB register; MISALIGN_TRAP_EN traps unaligned accesses.
// Latency: load data and write-back controls one cycle after EX/MEM; PCSrc/Branch_Target combinational.
// Backpressure: none, consumes one instruction per cycle; Flush squashes the instruction in MEM.
module etapa_mem_wb #(
    parameter int ADDR_W = 8,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              Flush,
    input  logic [31:0]       sumador2_EX_MEM,
    input  logic              Zero_Flag_EX_MEM,
    input  logic [31:0]       Resultado_ALU_EX_MEM,
    input  logic [31:0]       Read_Data_2_EX_MEM,
    input  logic [4:0]        Instruccion_MUX_EX_MEM,
    input  logic              Branch_EX_MEM,
    input  logic              MemToRead_EX_MEM,
    input  logic              MemToWrite_EX_MEM,
    input  logic              RegWrite_EX_MEM,
    input  logic              MemToReg_EX_MEM,
    output logic              PCSrc,
    output logic [31:0]       Branch_Target,
    output logic [31:0]       Read_Data_MEM_WB,
    output logic [31:0]       Resultado_ALU_MEM_WB,
    output logic [4:0]        Instruccion_MUX_MEM_WB,
    output logic              RegWrite_MEM_WB,
    output logic              MemToReg_MEM_WB,
    output logic [CNT_W-1:0]  Cuenta_Accesos,
    output logic              Error_Alineacion
);
    localparam int DEPTH = 1 << ADDR_W;

    logic [31:0]       mem [DEPTH];
    logic [ADDR_W-1:0] idx;
    logic              rd;
    logic              wr;
    logic              misal;
    logic              unused_addr_bits;

    assign idx = Resultado_ALU_EX_MEM[ADDR_W+1:2];
    assign rd  = MemToRead_EX_MEM  & ~Flush;
    assign wr  = MemToWrite_EX_MEM & ~Flush;

`ifdef MISALIGN_TRAP_EN
    assign misal = (rd | wr) & (Resultado_ALU_EX_MEM[1:0] != 2'b00);
`else
    assign misal = 1'b0;
`endif

    // Address bits above the memory index alias onto the same words.
    assign unused_addr_bits = ^{Resultado_ALU_EX_MEM[31:ADDR_W+2], Resultado_ALU_EX_MEM[1:0]};

    assign PCSrc         = Branch_EX_MEM & Zero_Flag_EX_MEM & ~Flush;
    assign Branch_Target = sumador2_EX_MEM;

    // Array is never cleared; a store coinciding with reset is dropped.
    always_ff @(posedge clk) begin
        if (wr && !misal && !rst) begin
            mem[idx] <= Read_Data_2_EX_MEM;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            Read_Data_MEM_WB       <= '0;
            Resultado_ALU_MEM_WB   <= '0;
            Instruccion_MUX_MEM_WB <= '0;
            RegWrite_MEM_WB        <= 1'b0;
            MemToReg_MEM_WB        <= 1'b0;
            Cuenta_Accesos         <= '0;
            Error_Alineacion       <= 1'b0;
        end else begin
            Read_Data_MEM_WB       <= (rd && !misal) ? mem[idx] : 32'h0;
            Resultado_ALU_MEM_WB   <= Resultado_ALU_EX_MEM;
            Instruccion_MUX_MEM_WB <= Instruccion_MUX_EX_MEM;
            RegWrite_MEM_WB        <= RegWrite_EX_MEM & ~Flush;
            MemToReg_MEM_WB        <= MemToReg_EX_MEM & ~Flush;
            if ((rd || wr) && (Cuenta_Accesos != {CNT_W{1'b1}})) begin
                Cuenta_Accesos <= Cuenta_Accesos + 1'b1;
            end
            if (misal) begin
                Error_Alineacion <= 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_etapa_mem_wb.sv
// Bench for etapa_mem_wb: directed vector table, hand sequences and random traffic against a reference model.
module tb_etapa_mem_wb;
    localparam int AW   = 8;
    localparam int CW   = 6;
    localparam int CMAX = (1 << CW) - 1;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          Flush = 1'b0;
    logic [31:0]   sumador2 = '0;
    logic          Zero = 1'b0;
    logic [31:0]   alu = '0;
    logic [31:0]   wdata = '0;
    logic [4:0]    dest = '0;
    logic          Branch = 1'b0;
    logic          MemRd = 1'b0;
    logic          MemWr = 1'b0;
    logic          RegWr = 1'b0;
    logic          MemToReg = 1'b0;
    logic          PCSrc;
    logic [31:0]   Branch_Target;
    logic [31:0]   Read_Data_MEM_WB;
    logic [31:0]   Resultado_ALU_MEM_WB;
    logic [4:0]    Instruccion_MUX_MEM_WB;
    logic          RegWrite_MEM_WB;
    logic          MemToReg_MEM_WB;
    logic [CW-1:0] Cuenta_Accesos;
    logic          Error_Alineacion;

    etapa_mem_wb #(.ADDR_W(AW), .CNT_W(CW)) dut (
        .clk(clk), .rst(rst), .Flush(Flush),
        .sumador2_EX_MEM(sumador2), .Zero_Flag_EX_MEM(Zero),
        .Resultado_ALU_EX_MEM(alu), .Read_Data_2_EX_MEM(wdata),
        .Instruccion_MUX_EX_MEM(dest), .Branch_EX_MEM(Branch),
        .MemToRead_EX_MEM(MemRd), .MemToWrite_EX_MEM(MemWr),
        .RegWrite_EX_MEM(RegWr), .MemToReg_EX_MEM(MemToReg),
        .PCSrc(PCSrc), .Branch_Target(Branch_Target),
        .Read_Data_MEM_WB(Read_Data_MEM_WB), .Resultado_ALU_MEM_WB(Resultado_ALU_MEM_WB),
        .Instruccion_MUX_MEM_WB(Instruccion_MUX_MEM_WB), .RegWrite_MEM_WB(RegWrite_MEM_WB),
        .MemToReg_MEM_WB(MemToReg_MEM_WB), .Cuenta_Accesos(Cuenta_Accesos),
        .Error_Alineacion(Error_Alineacion)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Reference model state: word memory, access count, sticky error.
    logic [31:0] m_mem [1 << AW];
    int          m_cnt = 0;
    bit          m_err = 1'b0;

`ifdef MISALIGN_TRAP_EN
    localparam bit TRAP = 1'b1;
`else
    localparam bit TRAP = 1'b0;
`endif

    typedef struct {
        bit          rd, wr, fl, rw, mtr;
        logic [31:0] addr, data;
        logic [4:0]  dst;
        logic [31:0] exp_rdata;
        int          exp_cnt;
        bit          exp_rw;
    } vec_t;

    typedef struct {
        bit          br, zf, fl;
        logic [31:0] tgt;
        bit          exp_pc;
    } pc_vec_t;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic idle();
        @(negedge clk);
        MemRd = 1'b0; MemWr = 1'b0; Flush = 1'b0; RegWr = 1'b0; MemToReg = 1'b0; Branch = 1'b0;
    endtask

    task automatic apply(input bit rd, input bit wr, input bit fl, input bit rw, input bit mtr,
                         input logic [31:0] a, input logic [31:0] d, input logic [4:0] dst);
        bit          erd, ewr, bad;
        int          w;
        logic [31:0] e_rdata;
        @(negedge clk);
        MemRd = rd; MemWr = wr; Flush = fl; RegWr = rw; MemToReg = mtr;
        alu = a; wdata = d; dest = dst; Branch = 1'b0;
        erd = rd && !fl;
        ewr = wr && !fl;
        w   = int'((a / 4) % (1 << AW));
        bad = TRAP && (erd || ewr) && (a % 4 != 0);
        e_rdata = (erd && !bad) ? m_mem[w] : 32'h0;
        if (ewr && !bad) m_mem[w] = d;
        if ((erd || ewr) && m_cnt < CMAX) m_cnt++;
        if (bad) m_err = 1'b1;
        @(posedge clk);
        #1;
        chk("rdata", Read_Data_MEM_WB, e_rdata);
        chk("alu_copy", Resultado_ALU_MEM_WB, a);
        chk("dest_copy", 32'(Instruccion_MUX_MEM_WB), 32'(dst));
        chk("regwrite", 32'(RegWrite_MEM_WB), 32'(rw && !fl));
        chk("memtoreg", 32'(MemToReg_MEM_WB), 32'(mtr && !fl));
        chk("count", 32'(Cuenta_Accesos), 32'(m_cnt));
        chk("align_err", 32'(Error_Alineacion), 32'(m_err));
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_rdata"}, Read_Data_MEM_WB, 32'h0);
        chk({tag, "_alu"}, Resultado_ALU_MEM_WB, 32'h0);
        chk({tag, "_dest"}, 32'(Instruccion_MUX_MEM_WB), 32'h0);
        chk({tag, "_regwrite"}, 32'(RegWrite_MEM_WB), 32'h0);
        chk({tag, "_memtoreg"}, 32'(MemToReg_MEM_WB), 32'h0);
        chk({tag, "_count"}, 32'(Cuenta_Accesos), 32'h0);
        chk({tag, "_err"}, 32'(Error_Alineacion), 32'h0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t    tbl [12];
        pc_vec_t pct [5];
        logic [31:0] a;

        tbl[0]  = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 32'h10,  32'hDEADBEEF, 5'd1,  32'h0,        1, 1'b0};
        tbl[1]  = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 32'h10,  32'h0,        5'd2,  32'hDEADBEEF, 2, 1'b1};
        tbl[2]  = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 32'h10,  32'h11111111, 5'd3,  32'h0,        3, 1'b0};
        tbl[3]  = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 32'h10,  32'h22222222, 5'd4,  32'h11111111, 4, 1'b1};
        tbl[4]  = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 32'h10,  32'h0,        5'd5,  32'h22222222, 5, 1'b1};
        tbl[5]  = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 32'h400, 32'hCAFE0001, 5'd6,  32'h0,        6, 1'b0};
        tbl[6]  = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 32'h0,   32'h0,        5'd7,  32'hCAFE0001, 7, 1'b1};
        tbl[7]  = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 32'h8,   32'h00000077, 5'd8,  32'h0,        8, 1'b0};
        tbl[8]  = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 32'h8,   32'h00000055, 5'd9,  32'h0,        8, 1'b0};
        tbl[9]  = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 32'h8,   32'h0,        5'd10, 32'h00000077, 9, 1'b1};
        tbl[10] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 32'h8,   32'h0,        5'd11, 32'h0,        9, 1'b0};
        tbl[11] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 32'h20,  32'h0,        5'd31, 32'h0,        9, 1'b1};

        pct[0] = '{1'b1, 1'b1, 1'b0, 32'h00400020, 1'b1};
        pct[1] = '{1'b1, 1'b0, 1'b0, 32'h00400020, 1'b0};
        pct[2] = '{1'b0, 1'b1, 1'b0, 32'h00401000, 1'b0};
        pct[3] = '{1'b1, 1'b1, 1'b1, 32'h00400040, 1'b0};
        pct[4] = '{1'b1, 1'b1, 1'b0, 32'hFFFFFFFC, 1'b1};

        repeat (2) @(posedge clk);
        #1;
        chk_all_zero("reset");
        @(negedge clk);
        rst = 1'b0;

        for (int i = 0; i < 12; i++) begin
            apply(tbl[i].rd, tbl[i].wr, tbl[i].fl, tbl[i].rw, tbl[i].mtr,
                  tbl[i].addr, tbl[i].data, tbl[i].dst);
            chk($sformatf("tbl%0d_rdata", i), Read_Data_MEM_WB, tbl[i].exp_rdata);
            chk($sformatf("tbl%0d_count", i), 32'(Cuenta_Accesos), 32'(tbl[i].exp_cnt));
            chk($sformatf("tbl%0d_regwrite", i), 32'(RegWrite_MEM_WB), 32'(tbl[i].exp_rw));
        end

        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            Branch = pct[i].br; Zero = pct[i].zf; Flush = pct[i].fl; sumador2 = pct[i].tgt;
            MemRd = 1'b0; MemWr = 1'b0;
            #1;
            chk($sformatf("pc%0d_pcsrc", i), 32'(PCSrc), 32'(pct[i].exp_pc));
            chk($sformatf("pc%0d_target", i), Branch_Target, pct[i].tgt);
        end
        idle();

        // Seed every word the random phase can touch so the model never sees X.
        for (int w = 0; w < 16; w++) begin
            apply(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 32'(w * 4), $urandom, 5'(w));
        end

        for (int n = 0; n < 200; n++) begin
            a = (32'($urandom_range(0, 3)) << 10) | (32'($urandom_range(0, 15)) << 2);
            if ($urandom_range(0, 3) == 0) a = a | 32'($urandom_range(1, 3));
            apply(1'($urandom), 1'($urandom), ($urandom_range(0, 7) == 0),
                  1'($urandom), 1'($urandom), a, $urandom, 5'($urandom));
        end

        chk("sat_reached", 32'(Cuenta_Accesos), 32'(CMAX));
        apply(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'h4, 32'h0, 5'd0);
        chk("sat_hold", 32'(Cuenta_Accesos), 32'(CMAX));

        apply(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 32'h10, 32'h22222222, 5'd0);
        apply(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 32'h12, 32'h99999999, 5'd0);
        chk("misalign_err", 32'(Error_Alineacion), 32'(TRAP));
        apply(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'h10, 32'h0, 5'd0);
        chk("misalign_nowrite", Read_Data_MEM_WB, TRAP ? 32'h22222222 : 32'h99999999);
        apply(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 5'd0);
        chk("misalign_sticky", 32'(Error_Alineacion), 32'(TRAP));

        // Asynchronous reset between edges, then hold it over a store that must be dropped.
        apply(1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 32'hABC, 32'h0, 5'd7);
        #3;
        rst = 1'b1;
        #1;
        chk_all_zero("async_rst");
        @(negedge clk);
        MemWr = 1'b1; MemRd = 1'b0; Flush = 1'b0; alu = 32'h8; wdata = 32'h00000BAD;
        @(posedge clk);
        #1;
        chk_all_zero("rst_hold");
        @(negedge clk);
        rst = 1'b0;
        MemWr = 1'b0;
        m_cnt = 0;
        m_err = 1'b0;
        apply(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 32'h8, 32'h0, 5'd3);
        chk("post_rst_count", 32'(Cuenta_Accesos), 32'h1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
